aes_key_schedule_iter: RTL and testbench

Iterative AES key-expansion engine, one schedule word per clock. Loads a cipher key of Nk words and stores all 4*(Nr+1) schedule words. Exposes any round key through an indexed read port. Sits directly upstream of the decryption datapath, which fetches round keys Nr down to 0 instead of expanding the key combinationally.

---
 rtl/aes_key_schedule_iter.sv | 157 +++++++++++++++
 tb/tb_aes_key_schedule_iter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES key expansion: writes one schedule word per clock into a word store
// and serves any round key through a zero-latency indexed read port.
//
// state  | meaning
// IDLE   | no schedule held, waiting for start
// EXPAND | writing w[i], one word per clock
// DONE   | full schedule held, rk_out valid
module aes_key_schedule_iter #(
    parameter int Nk = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [Nk*32-1:0] key_in,
    output logic             busy,
    output logic             ready,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk_out
);
    localparam int Nr = Nk + 6;
    localparam int NW = 4 * (Nr + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  i_mod_q, i_mod_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] w_q [NW];
    logic [31:0] w_d [NW];

    logic        load;
    logic        expand;
    logic        last_word;
    logic [31:0] temp;
    logic [31:0] w_prev;
    logic [31:0] w_new;
    logic [5:0]  rk_base;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as the field inverse a^254 (which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_EXPAND;
            S_EXPAND: if (last_word) state_d = S_DONE;
            S_DONE:   if (start) state_d = S_EXPAND;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_EXPAND);
        ready  = (state_q == S_DONE);
        expand = (state_q == S_EXPAND);
        load   = start && (state_q != S_EXPAND);
    end

    always_comb begin
        last_word = (i_q == 6'(NW - 1));
        temp      = w_q[i_q - 6'd1];
        w_prev    = w_q[i_q - 6'(Nk)];
        if (i_mod_q == 3'd0) begin
            w_new = w_prev ^ sub_word({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h0};
        end else if (Nk == 8 && i_mod_q == 3'd4) begin
            w_new = w_prev ^ sub_word(temp);
        end else begin
            w_new = w_prev ^ temp;
        end
    end

    always_comb begin
        i_d     = i_q;
        i_mod_d = i_mod_q;
        rcon_d  = rcon_q;
        w_d     = w_q;
        if (load) begin
            i_d     = 6'(Nk);
            i_mod_d = 3'd0;
            rcon_d  = 8'h01;
            for (int k = 0; k < Nk; k++) begin
                w_d[k] = key_in[(Nk-1-k)*32 +: 32];
            end
        end else if (expand) begin
            w_d[i_q] = w_new;
            i_d      = i_q + 6'd1;
            i_mod_d  = (i_mod_q == 3'(Nk - 1)) ? 3'd0 : i_mod_q + 3'd1;
            if (i_mod_q == 3'd0) rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q     <= '0;
            i_mod_q <= '0;
            rcon_q  <= '0;
        end else begin
            i_q     <= i_d;
            i_mod_q <= i_mod_d;
            rcon_q  <= rcon_d;
        end
    end

    // Word store carries no reset; ready gates every read of it.
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    always_comb begin
        rk_base = {rk_idx, 2'b00};
        rk_out  = '0;
        if (ready && rk_idx <= 4'(Nr)) begin
            rk_out = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Scoreboard bench for aes_key_schedule_iter: three instances (Nk=4/6/8), reference
// key expansion and inverse cipher built from field arithmetic inside the bench.
`timescale 1ns/1ps
module tb_aes_key_schedule_iter;

    localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K6     = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K8     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] DEC_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DEC_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   st = 3'b000;
    logic [2:0]   bsy;
    logic [2:0]   rdy;
    logic [127:0] key4 = '0;
    logic [191:0] key6 = '0;
    logic [255:0] key8 = '0;
    logic [3:0]   rki [3];
    logic [127:0] rko [3];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int items_done = 0;
    int n_exp = 0;

    logic [7:0] sbox [256];
    logic [7:0] inv_sbox [256];

    int           q_dut[$];
    int           q_start[$];
    int           q_nr[$];
    int           q_kn[$];
    int           q_ki[$];
    bit           q_dec[$];
    logic [127:0] q_rk[$];
    logic [127:0] q_kv[$];

    aes_key_schedule_iter #(.Nk(4)) dut4 (
        .clk(clk), .rst(rst), .start(st[0]), .key_in(key4), .busy(bsy[0]),
        .ready(rdy[0]), .rk_idx(rki[0]), .rk_out(rko[0]));
    aes_key_schedule_iter #(.Nk(6)) dut6 (
        .clk(clk), .rst(rst), .start(st[1]), .key_in(key6), .busy(bsy[1]),
        .ready(rdy[1]), .rk_idx(rki[1]), .rk_out(rko[1]));
    aes_key_schedule_iter #(.Nk(8)) dut8 (
        .clk(clk), .rst(rst), .start(st[2]), .key_in(key8), .busy(bsy[2]),
        .ready(rdy[2]), .rk_idx(rki[2]), .rk_out(rko[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    // S-box tables: brute-force multiplicative inverse, then the bitwise affine formula.
    task automatic build_sbox();
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            for (int k = 0; k < 8; k++) begin
                s[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8] ^ b[(k+7)%8] ^ c[k];
            end
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Computes the expected schedule, issues the start pulse and queues the expectation.
    task automatic go(input int d, input logic [255:0] key, input bit dec, output int se);
        int          nk;
        int          nr;
        logic [31:0] w[$];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = (d == 0) ? 4 : (d == 1) ? 6 : 8;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w.push_back(key[(nk-1-i)*32 +: 32]);
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w.push_back(w[i-nk] ^ t);
        end
        @(negedge clk);
        case (d)
            0:       key4 = key[127:0];
            1:       key6 = key[191:0];
            default: key8 = key;
        endcase
        st[d] = 1'b1;
        se = cyc + 1;
        q_dut.push_back(d);
        q_start.push_back(se);
        q_nr.push_back(nr);
        q_kn.push_back(0);
        q_dec.push_back(dec);
        for (int r = 0; r <= nr; r++) q_rk.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        n_exp++;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic kat(input int idx, input logic [127:0] v);
        q_ki.push_back(idx);
        q_kv.push_back(v);
        q_kn[q_kn.size()-1] += 1;
    endtask

    task automatic flush();
        q_dut.delete(); q_start.delete(); q_nr.delete(); q_kn.delete();
        q_ki.delete(); q_kv.delete(); q_dec.delete(); q_rk.delete();
        n_exp = items_done;
    endtask

    task automatic wait_items();
        for (int c = 0; c < 400 && items_done < n_exp; c++) @(negedge clk);
        if (items_done < n_exp) begin
            checks++;
            failures++;
            $display("FAIL wait_ready actual=timeout required=ready_within_400_cycles");
        end
    endtask

    task automatic check_item(input int d);
        int           dd;
        int           se;
        int           nr;
        int           kn;
        int           ki;
        bit           dec;
        logic [127:0] ex;
        logic [127:0] rkl [15];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] pt;
        if (q_dut.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready dut=%0d actual=ready required=no_pending_start", d);
            return;
        end
        dd  = q_dut.pop_front();
        se  = q_start.pop_front();
        nr  = q_nr.pop_front();
        kn  = q_kn.pop_front();
        dec = q_dec.pop_front();
        chk("dut_select", 128'(d), 128'(dd));
        chk($sformatf("latency_nk%0d", nr - 6), 128'(cyc - se), 128'(4 * (nr + 1) - (nr - 6)));
        for (int r = 0; r <= nr; r++) begin
            ex = q_rk.pop_front();
            rki[d] = 4'(r);
            #1;
            rkl[r] = rko[d];
            chk($sformatf("rk%0d_nk%0d", r, nr - 6), rko[d], ex);
        end
        rki[d] = 4'(nr + 1);
        #1 chk($sformatf("rk_over_nk%0d", nr - 6), rko[d], 128'h0);
        rki[d] = 4'd15;
        #1 chk($sformatf("rk15_nk%0d", nr - 6), rko[d], 128'h0);
        for (int k = 0; k < kn; k++) begin
            ki = q_ki.pop_front();
            ex = q_kv.pop_front();
            rki[d] = 4'(ki);
            #1 chk($sformatf("kat_rk%0d_nk%0d", ki, nr - 6), rko[d], ex);
        end
        if (dec) begin
            for (int k = 0; k < 16; k++) s[k] = DEC_CT[127-8*k -: 8] ^ rkl[nr][127-8*k -: 8];
            for (int rnd = nr - 1; rnd >= 0; rnd--) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
                for (int k = 0; k < 16; k++) s[k] = inv_sbox[t[k]] ^ rkl[rnd][127-8*k -: 8];
                if (rnd > 0) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                        s[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                        s[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                        s[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
                    end
                end
            end
            for (int k = 0; k < 16; k++) pt[127-8*k -: 8] = s[k];
            chk("decrypt", pt, DEC_PT);
        end
        rki[d] = 4'd0;
        items_done++;
    endtask

    initial begin : monitor
        logic [2:0] prev;
        prev = 3'b000;
        for (int d = 0; d < 3; d++) rki[d] = 4'd0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rdy[d] && !prev[d]) check_item(d);
                prev[d] = rdy[d];
            end
        end
    end

    initial begin : stimulus
        int           se;
        logic [255:0] rk;
        build_sbox();
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_busy%0d", d), 128'(bsy[d]), 128'h0);
            chk($sformatf("reset_ready%0d", d), 128'(rdy[d]), 128'h0);
            chk($sformatf("reset_rk_out%0d", d), rko[d], 128'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        go(0, 256'(K1), 1'b0, se);
        kat(0, K1);
        kat(1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        kat(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("busy_after_start", 128'(bsy[0]), 128'h1);
        wait_items();

        go(0, 256'(K2), 1'b0, se);
        kat(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_items();

        go(1, 256'(K6), 1'b0, se);
        kat(12, 128'ha4970a331a78dc09c418c271e3a41d5d);
        wait_items();
        go(2, K8, 1'b0, se);
        kat(14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        wait_items();

        for (int n = 0; n < 3; n++) begin
            for (int d = 0; d < 3; d++) begin
                rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                go(d, rk, 1'b0, se);
                wait_items();
            end
        end

        // Second start mid-expansion, with a different key, must be ignored.
        go(0, 256'(K1), 1'b0, se);
        kat(1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        kat(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        for (int c = 0; c < 100 && cyc < se + 19; c++) @(negedge clk);
        st[0] = 1'b1;
        key4  = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_mid_expand", 128'(bsy[0]), 128'h1);
        @(negedge clk);
        st[0] = 1'b0;
        wait_items();

        // Reset in the middle of an expansion, then a clean restart.
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        go(0, rk, 1'b0, se);
        for (int c = 0; c < 100 && cyc < se + 25; c++) @(negedge clk);
        chk("busy_before_rst", 128'(bsy[0]), 128'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 128'(bsy[0]), 128'h0);
        chk("rst_mid_ready", 128'(rdy[0]), 128'h0);
        chk("rst_mid_rk_out", rko[0], 128'h0);
        flush();
        @(negedge clk);
        rst = 1'b0;
        go(0, 256'(K2), 1'b0, se);
        kat(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_items();

        // Restart from DONE; the resulting schedule also feeds the inverse cipher.
        chk("ready_in_done", 128'(rdy[0]), 128'h1);
        go(0, 256'(K1), 1'b1, se);
        chk("restart_ready_fall", 128'(rdy[0]), 128'h0);
        chk("restart_busy_rise", 128'(bsy[0]), 128'h1);
        kat(0, K1);
        kat(10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        wait_items();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
